bsg_nonsynth_axil_to_dpi_fifo: RTL and testbench

AXI4-Lite subordinate for cosim that decouples the bus from the host-side DPI poller with buffered, credit-limited queues.
- AW and W beats are accepted independently, paired, and queued as write requests.
- AR beats are queued as read requests.
- The host pushes B and R responses into response queues, which drain onto the bus in order.
- Sits between the DUT's AXI-L manager port and the C++ DPI driver, replacing cycle-by-cycle host polling of every AXI pin.

---
 rtl/bsg_nonsynth_axil_to_dpi_fifo.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_bsg_nonsynth_axil_to_dpi_fifo.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_nonsynth_axil_to_dpi_fifo.sv
// AXI4-Lite subordinate that buffers AW/W/AR requests toward a DPI host
// poller and B/R responses from it, with credit-limited in-flight counts.
// Ports: AXI-L subordinate channels (aw*, w*, b*, ar*, r*); host request
// heads wr_v_o/wr_addr_o/wr_data_o/wr_strb_o/wr_yumi_i and
// rd_v_o/rd_addr_o/rd_yumi_i; host response pushes b_v_i/b_resp_i/b_ready_o
// and r_v_i/r_data_i/r_resp_i/r_ready_o; wr/rd_outstanding_o; sticky err_o.

module bsg_nonsynth_axil_to_dpi_fifo_q
  #(parameter int width_p = 8
  , parameter int els_p = 4)
  (input  logic clk_i
  , input  logic reset_i
  , input  logic v_i
  , input  logic [width_p-1:0] data_i
  , output logic full_o
  , output logic empty_o
  , output logic [width_p-1:0] data_o
  , input  logic yumi_i
  , output logic [$clog2(els_p+1)-1:0] count_o);

  localparam int cnt_w_lp = $clog2(els_p+1);
  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [ptr_w_lp-1:0] last_lp = ptr_w_lp'(els_p-1);
  localparam logic [cnt_w_lp-1:0] full_lp = cnt_w_lp'(els_p);

  logic [width_p-1:0] mem_r [els_p];
  logic [ptr_w_lp-1:0] wptr_r, rptr_r;
  logic [cnt_w_lp-1:0] cnt_r;
  logic enq, deq;

  assign full_o  = (cnt_r == full_lp);
  assign empty_o = (cnt_r == '0);
  assign enq     = v_i & ~full_o;
  assign deq     = yumi_i & ~empty_o;
  assign data_o  = mem_r[rptr_r];
  assign count_o = cnt_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cnt_r  <= '0;
    end else begin
      if (enq)
        wptr_r <= (wptr_r == last_lp) ? '0 : wptr_r + ptr_w_lp'(1);
      if (deq)
        rptr_r <= (rptr_r == last_lp) ? '0 : rptr_r + ptr_w_lp'(1);
      cnt_r <= cnt_r + cnt_w_lp'(enq) - cnt_w_lp'(deq);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq)
      mem_r[wptr_r] <= data_i;
  end

endmodule

module bsg_nonsynth_axil_to_dpi_fifo
  #(parameter int addr_width_p = 32
  , parameter int data_width_p = 32
  , parameter int els_p = 4
  , parameter int max_outstanding_p = 4)
  (input  logic clk_i
  , input  logic reset_i
  , input  logic [addr_width_p-1:0] awaddr_i
  , input  logic [2:0] awprot_i
  , input  logic awvalid_i
  , output logic awready_o
  , input  logic [data_width_p-1:0] wdata_i
  , input  logic [data_width_p/8-1:0] wstrb_i
  , input  logic wvalid_i
  , output logic wready_o
  , output logic [1:0] bresp_o
  , output logic bvalid_o
  , input  logic bready_i
  , input  logic [addr_width_p-1:0] araddr_i
  , input  logic [2:0] arprot_i
  , input  logic arvalid_i
  , output logic arready_o
  , output logic [data_width_p-1:0] rdata_o
  , output logic [1:0] rresp_o
  , output logic rvalid_o
  , input  logic rready_i
  , output logic wr_v_o
  , output logic [addr_width_p-1:0] wr_addr_o
  , output logic [data_width_p-1:0] wr_data_o
  , output logic [data_width_p/8-1:0] wr_strb_o
  , input  logic wr_yumi_i
  , output logic rd_v_o
  , output logic [addr_width_p-1:0] rd_addr_o
  , input  logic rd_yumi_i
  , input  logic b_v_i
  , input  logic [1:0] b_resp_i
  , output logic b_ready_o
  , input  logic r_v_i
  , input  logic [data_width_p-1:0] r_data_i
  , input  logic [1:0] r_resp_i
  , output logic r_ready_o
  , output logic [$clog2(2*els_p+1)-1:0] wr_outstanding_o
  , output logic [$clog2(2*els_p+1)-1:0] rd_outstanding_o
  , output logic err_o);

  localparam int sw_lp = data_width_p/8;
  localparam int oc_w_lp = $clog2(2*els_p+1);
  localparam int fc_w_lp = $clog2(els_p+1);
  localparam int wrq_w_lp = addr_width_p+data_width_p+sw_lp;
  localparam int rq_w_lp = data_width_p+2;
  localparam logic [oc_w_lp-1:0] max_lp = oc_w_lp'(max_outstanding_p);

  if (els_p < 2) begin : g_els_chk
    $error("els_p must be at least 2");
  end
  if (data_width_p % 8 != 0) begin : g_dw_chk
    $error("data_width_p must be a multiple of 8");
  end
  if (max_outstanding_p < 1 || max_outstanding_p > 2*els_p) begin : g_mo_chk
    $error("max_outstanding_p out of range");
  end

  logic aw_full_r, w_full_r;
  logic [addr_width_p-1:0] aw_addr_r;
  logic [2:0] aw_prot_r, ar_prot_r;
  logic [data_width_p-1:0] w_data_r;
  logic [sw_lp-1:0] w_strb_r;
  logic [oc_w_lp-1:0] wr_out_r, rd_out_r;
  logic err_r;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs, pair_fire;
  logic wrq_full, wrq_empty, rdq_full, rdq_empty;
  logic bq_full, bq_empty, rq_full, rq_empty;
  logic [wrq_w_lp-1:0] wrq_dout;
  logic [rq_w_lp-1:0] rq_dout;
  logic [fc_w_lp-1:0] wrq_cnt, rdq_cnt, bq_cnt, rq_cnt;
  logic b_push, r_push, b_ok, r_ok, b_enq, r_enq;
  logic wr_deq, rd_deq, err_set;
  logic unused;

  assign unused = ^{aw_prot_r, ar_prot_r, wrq_cnt, rdq_cnt};

  assign pair_fire = aw_full_r & w_full_r & ~wrq_full
                   & (wr_out_r < max_lp);

  // a full holding register can take a new beat as it drains
  assign awready_o = ~reset_i & (~aw_full_r | pair_fire);
  assign wready_o  = ~reset_i & (~w_full_r | pair_fire);
  assign arready_o = ~reset_i & ~rdq_full & (rd_out_r < max_lp);

  assign aw_hs = awvalid_i & awready_o;
  assign w_hs  = wvalid_i & wready_o;
  assign ar_hs = arvalid_i & arready_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      aw_full_r <= 1'b0;
      w_full_r  <= 1'b0;
    end else begin
      if (aw_hs)
        aw_full_r <= 1'b1;
      else if (pair_fire)
        aw_full_r <= 1'b0;
      if (w_hs)
        w_full_r <= 1'b1;
      else if (pair_fire)
        w_full_r <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (aw_hs) begin
      aw_addr_r <= awaddr_i;
      aw_prot_r <= awprot_i;
    end
    if (w_hs) begin
      w_data_r <= wdata_i;
      w_strb_r <= wstrb_i;
    end
    if (ar_hs)
      ar_prot_r <= arprot_i;
  end

  assign wr_v_o = ~reset_i & ~wrq_empty;
  assign rd_v_o = ~reset_i & ~rdq_empty;
  assign wr_deq = wr_yumi_i & wr_v_o;
  assign rd_deq = rd_yumi_i & rd_v_o;
  assign {wr_addr_o, wr_data_o, wr_strb_o} = wrq_dout;

  bsg_nonsynth_axil_to_dpi_fifo_q
    #(.width_p(wrq_w_lp), .els_p(els_p))
  wrq
    (.clk_i(clk_i)
    ,.reset_i(reset_i)
    ,.v_i(pair_fire)
    ,.data_i({aw_addr_r, w_data_r, w_strb_r})
    ,.full_o(wrq_full)
    ,.empty_o(wrq_empty)
    ,.data_o(wrq_dout)
    ,.yumi_i(wr_deq)
    ,.count_o(wrq_cnt));

  bsg_nonsynth_axil_to_dpi_fifo_q
    #(.width_p(addr_width_p), .els_p(els_p))
  rdq
    (.clk_i(clk_i)
    ,.reset_i(reset_i)
    ,.v_i(ar_hs)
    ,.data_i(araddr_i)
    ,.full_o(rdq_full)
    ,.empty_o(rdq_empty)
    ,.data_o(rd_addr_o)
    ,.yumi_i(rd_deq)
    ,.count_o(rdq_cnt));

  // a response is only owed for a request not already answered
  assign b_ready_o = ~reset_i & ~bq_full;
  assign r_ready_o = ~reset_i & ~rq_full;
  assign b_push = b_v_i & b_ready_o;
  assign r_push = r_v_i & r_ready_o;
  assign b_ok   = wr_out_r > oc_w_lp'(bq_cnt);
  assign r_ok   = rd_out_r > oc_w_lp'(rq_cnt);
  assign b_enq  = b_push & b_ok;
  assign r_enq  = r_push & r_ok;

  assign bvalid_o = ~reset_i & ~bq_empty;
  assign rvalid_o = ~reset_i & ~rq_empty;
  assign b_hs = bvalid_o & bready_i;
  assign r_hs = rvalid_o & rready_i;
  assign {rdata_o, rresp_o} = rq_dout;

  bsg_nonsynth_axil_to_dpi_fifo_q
    #(.width_p(2), .els_p(els_p))
  bq
    (.clk_i(clk_i)
    ,.reset_i(reset_i)
    ,.v_i(b_enq)
    ,.data_i(b_resp_i)
    ,.full_o(bq_full)
    ,.empty_o(bq_empty)
    ,.data_o(bresp_o)
    ,.yumi_i(b_hs)
    ,.count_o(bq_cnt));

  bsg_nonsynth_axil_to_dpi_fifo_q
    #(.width_p(rq_w_lp), .els_p(els_p))
  rq
    (.clk_i(clk_i)
    ,.reset_i(reset_i)
    ,.v_i(r_enq)
    ,.data_i({r_data_i, r_resp_i})
    ,.full_o(rq_full)
    ,.empty_o(rq_empty)
    ,.data_o(rq_dout)
    ,.yumi_i(r_hs)
    ,.count_o(rq_cnt));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_out_r <= '0;
    end else if (pair_fire & ~b_hs) begin
      wr_out_r <= wr_out_r + oc_w_lp'(1);
    end else if (~pair_fire & b_hs) begin
      wr_out_r <= wr_out_r - oc_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_out_r <= '0;
    end else if (ar_hs & ~r_hs) begin
      rd_out_r <= rd_out_r + oc_w_lp'(1);
    end else if (~ar_hs & r_hs) begin
      rd_out_r <= rd_out_r - oc_w_lp'(1);
    end
  end

  assign err_set = (b_push & ~b_ok) | (r_push & ~r_ok)
                 | (wr_yumi_i & ~wr_v_o) | (rd_yumi_i & ~rd_v_o);

  always_ff @(posedge clk_i) begin
    if (reset_i)
      err_r <= 1'b0;
    else if (err_set)
      err_r <= 1'b1;
  end

  assign wr_outstanding_o = wr_out_r;
  assign rd_outstanding_o = rd_out_r;
  assign err_o = err_r;

endmodule

// File: tb/tb_bsg_nonsynth_axil_to_dpi_fifo.sv
// Bench for bsg_nonsynth_axil_to_dpi_fifo: directed scenarios plus a
// randomized phase, all checked by a queue scoreboard and monitor.

module tb_bsg_nonsynth_axil_to_dpi_fifo;

  logic clk = 0;
  logic reset = 1;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, r_data = 0;
  logic [2:0] awprot = 0, arprot = 0;
  logic [3:0] wstrb = 0;
  logic awvalid = 0, wvalid = 0, arvalid = 0, bready = 0, rready = 0;
  logic wr_yumi = 0, rd_yumi = 0, b_v = 0, r_v = 0;
  logic [1:0] b_resp = 0, r_resp = 0;
  logic awready, wready, arready, bvalid, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata, wr_addr, wr_data, rd_addr;
  logic [3:0] wr_strb;
  logic wr_v, rd_v, b_ready, r_ready, err;
  logic [3:0] wr_out, rd_out;

  int total = 0;
  int bad = 0;
  logic [31:0] aw_q[$];
  logic [35:0] w_q[$];
  logic [67:0] exp_wr[$];
  logic [31:0] exp_rd[$];
  logic [1:0] exp_b[$];
  logic [33:0] exp_r[$];
  int pend_b = 0;
  int pend_r = 0;
  int n_ar = 0;
  bit spur = 0;

  bsg_nonsynth_axil_to_dpi_fifo dut
    (.clk_i(clk), .reset_i(reset)
    ,.awaddr_i(awaddr), .awprot_i(awprot), .awvalid_i(awvalid)
    ,.awready_o(awready)
    ,.wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid)
    ,.wready_o(wready)
    ,.bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready)
    ,.araddr_i(araddr), .arprot_i(arprot), .arvalid_i(arvalid)
    ,.arready_o(arready)
    ,.rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid)
    ,.rready_i(rready)
    ,.wr_v_o(wr_v), .wr_addr_o(wr_addr), .wr_data_o(wr_data)
    ,.wr_strb_o(wr_strb), .wr_yumi_i(wr_yumi)
    ,.rd_v_o(rd_v), .rd_addr_o(rd_addr), .rd_yumi_i(rd_yumi)
    ,.b_v_i(b_v), .b_resp_i(b_resp), .b_ready_o(b_ready)
    ,.r_v_i(r_v), .r_data_i(r_data), .r_resp_i(r_resp)
    ,.r_ready_o(r_ready)
    ,.wr_outstanding_o(wr_out), .rd_outstanding_o(rd_out)
    ,.err_o(err));

  always #5 clk = ~clk;

  function automatic void check(string nm, logic [67:0] got,
                                logic [67:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endfunction

  // one clock: record what the upcoming edge accepts, then retire it
  task automatic cyc();
    bit aw_a, w_a, ar_a, b_a, r_a;
    #1;
    aw_a = awvalid && awready;
    w_a  = wvalid && wready;
    ar_a = arvalid && arready;
    b_a  = b_v && b_ready;
    r_a  = r_v && r_ready;
    if (aw_a) aw_q.push_back(awaddr);
    if (w_a) w_q.push_back({wdata, wstrb});
    while (aw_q.size() > 0 && w_q.size() > 0)
      exp_wr.push_back({aw_q.pop_front(), w_q.pop_front()});
    if (ar_a) begin
      exp_rd.push_back(araddr);
      n_ar++;
    end
    if (b_a && !spur) begin
      exp_b.push_back(b_resp);
      pend_b--;
    end
    if (r_a) begin
      exp_r.push_back({r_data, r_resp});
      pend_r--;
    end
    if (wr_yumi && wr_v) pend_b++;
    if (rd_yumi && rd_v) pend_r++;
    @(negedge clk);
    if (aw_a) awvalid = 0;
    if (w_a) wvalid = 0;
    if (ar_a) arvalid = 0;
    if (b_a) b_v = 0;
    if (r_a) r_v = 0;
    wr_yumi = 0;
    rd_yumi = 0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    awvalid = 1; awaddr = a; awprot = 3'($urandom);
    wvalid = 1; wdata = d; wstrb = s;
    cyc();
  endtask

  task automatic do_read(input logic [31:0] a);
    arvalid = 1; araddr = a; arprot = 3'($urandom);
    cyc();
  endtask

  task automatic push_b(input logic [1:0] rs);
    b_v = 1; b_resp = rs;
    cyc();
  endtask

  task automatic push_r(input logic [31:0] d);
    r_v = 1; r_data = d; r_resp = 0;
    cyc();
  endtask

  // monitor: compares every DUT-presented transfer against the queues
  always begin
    @(negedge clk);
    #2;
    if (!reset) begin
      check("wr_out_le_max", 68'(wr_out <= 4), 1);
      check("rd_out_le_max", 68'(rd_out <= 4), 1);
    end
    if (wr_v && wr_yumi) begin
      check("wr_expected", 68'(exp_wr.size() > 0), 1);
      if (exp_wr.size() > 0)
        check("wr_req", {wr_addr, wr_data, wr_strb}, exp_wr.pop_front());
    end
    if (rd_v && rd_yumi) begin
      check("rd_expected", 68'(exp_rd.size() > 0), 1);
      if (exp_rd.size() > 0)
        check("rd_req", rd_addr, exp_rd.pop_front());
    end
    if (bvalid && bready) begin
      check("b_expected", 68'(exp_b.size() > 0), 1);
      if (exp_b.size() > 0)
        check("bresp", bresp, exp_b.pop_front());
    end
    if (rvalid && rready) begin
      check("r_expected", 68'(exp_r.size() > 0), 1);
      if (exp_r.size() > 0)
        check("rbeat", {rdata, rresp}, exp_r.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int offered;
    bit done;
    @(negedge clk);
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_valids", {wr_v, rd_v, bvalid, rvalid}, 0);
    check("rst_counts", {wr_out, rd_out}, 0);
    check("rst_err", err, 0);
    cyc();
    cyc();
    reset = 0;

    // W leads AW by three cycles
    wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    cyc();
    cyc();
    cyc();
    awvalid = 1; awaddr = 32'h10;
    cyc();
    check("wr_v_n1", wr_v, 0);
    cyc();
    check("wr_v_n2", wr_v, 1);
    check("wr_addr_n2", wr_addr, 32'h10);
    check("wr_out_1", wr_out, 1);
    wr_yumi = 1;
    cyc();
    push_b(2'b00);
    check("bvalid_next", bvalid, 1);
    check("bresp_next", bresp, 0);
    bready = 1;
    cyc();
    bready = 0;
    check("wr_out_back0", wr_out, 0);

    // reads up to the credit limit with no host service
    a0 = n_ar;
    offered = 0;
    for (int i = 0; i < 8; i++) begin
      if (!arvalid && offered < 6) begin
        arvalid = 1;
        araddr = 32'h100 + 32'(offered * 4);
        offered++;
      end
      cyc();
    end
    check("ar_accepted4", n_ar - a0, 4);
    check("arready_low", arready, 0);
    check("rd_out_4", rd_out, 4);
    rd_yumi = 1;
    cyc();
    push_r(32'd1);
    check("arready_still_low", arready, 0);
    rready = 1;
    cyc();
    rready = 0;
    check("ar5_ready", arready, 1);
    cyc();
    check("ar_accepted5", n_ar - a0, 5);
    check("rd_out_4b", rd_out, 4);

    // R backpressure
    for (int k = 0; k < 4; k++) begin
      rd_yumi = 1;
      cyc();
    end
    for (int k = 1; k <= 4; k++) push_r(32'(k));
    check("r_ready_full", r_ready, 0);
    check("r_head", {rvalid, rdata}, {1'b1, 32'd1});
    cyc();
    cyc();
    check("r_hold", {rvalid, rdata}, {1'b1, 32'd1});
    rready = 1;
    for (int k = 1; k <= 4; k++) begin
      check("r_order", rdata, 32'(k));
      cyc();
    end
    rready = 0;
    check("rd_out_drained", rd_out, 0);
    check("rvalid_drained", rvalid, 0);

    // simultaneous AR and R handshakes
    do_read(32'h200);
    do_read(32'h204);
    rd_yumi = 1;
    cyc();
    rd_yumi = 1;
    cyc();
    push_r(32'h55);
    check("rd_out_pre", rd_out, 2);
    arvalid = 1; araddr = 32'h208;
    rready = 1;
    cyc();
    rready = 0;
    check("rd_simul", rd_out, 2);
    rd_yumi = 1;
    cyc();
    push_r(32'h66);
    push_r(32'h77);
    rready = 1;
    cyc();
    cyc();
    rready = 0;
    check("rd_out_clean", rd_out, 0);

    // simultaneous pair_fire and B handshake
    do_write(32'h300, 32'h1111, 4'h3);
    cyc();
    wr_yumi = 1;
    cyc();
    push_b(2'b01);
    do_write(32'h304, 32'h2222, 4'hC);
    check("wr_out_pre", wr_out, 1);
    bready = 1;
    cyc();
    bready = 0;
    check("wr_simul", wr_out, 1);
    cyc();
    wr_yumi = 1;
    cyc();
    push_b(2'b10);
    bready = 1;
    cyc();
    bready = 0;
    check("wr_out_clean", wr_out, 0);

    // spurious B push
    spur = 1;
    push_b(2'b10);
    spur = 0;
    check("spur_bvalid", bvalid, 0);
    check("spur_err", err, 1);
    cyc();
    cyc();
    check("err_sticky", err, 1);

    // reset with work in flight
    do_write(32'h400, 32'hA5A5, 4'hF);
    do_write(32'h404, 32'h5A5A, 4'hF);
    do_read(32'h408);
    cyc();
    reset = 1;
    cyc();
    reset = 0;
    aw_q.delete(); w_q.delete();
    exp_wr.delete(); exp_rd.delete();
    exp_b.delete(); exp_r.delete();
    pend_b = 0; pend_r = 0;
    check("rst2_valids", {wr_v, rd_v, bvalid, rvalid}, 0);
    check("rst2_counts", {wr_out, rd_out}, 0);
    check("rst2_err", err, 0);
    do_write(32'h500, 32'hCAFEF00D, 4'h6);
    cyc();
    wr_yumi = 1;
    cyc();
    push_b(2'b11);
    bready = 1;
    cyc();
    bready = 0;
    check("rst2_write_done", wr_out, 0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if (!awvalid && $urandom_range(0, 2) == 0) begin
        awvalid = 1; awaddr = $urandom; awprot = 3'($urandom);
      end
      if (!wvalid && $urandom_range(0, 2) == 0) begin
        wvalid = 1; wdata = $urandom; wstrb = 4'($urandom);
      end
      if (!arvalid && $urandom_range(0, 2) == 0) begin
        arvalid = 1; araddr = $urandom; arprot = 3'($urandom);
      end
      bready = ($urandom_range(0, 1) == 1);
      rready = ($urandom_range(0, 1) == 1);
      wr_yumi = wr_v && ($urandom_range(0, 1) == 1);
      rd_yumi = rd_v && ($urandom_range(0, 1) == 1);
      if (!b_v && pend_b > 0 && $urandom_range(0, 1) == 1) begin
        b_v = 1; b_resp = 2'($urandom);
      end
      if (!r_v && pend_r > 0 && $urandom_range(0, 1) == 1) begin
        r_v = 1; r_data = $urandom; r_resp = 2'($urandom);
      end
      cyc();
    end

    // drain everything, completing any unpaired AW or W
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (aw_q.size() > 0 && !wvalid) begin
        wvalid = 1; wdata = $urandom; wstrb = 4'($urandom);
      end
      if (w_q.size() > 0 && !awvalid) begin
        awvalid = 1; awaddr = $urandom;
      end
      bready = 1;
      rready = 1;
      wr_yumi = wr_v;
      rd_yumi = rd_v;
      if (!b_v && pend_b > 0) begin
        b_v = 1; b_resp = 2'($urandom);
      end
      if (!r_v && pend_r > 0) begin
        r_v = 1; r_data = $urandom; r_resp = 2'($urandom);
      end
      cyc();
      done = !awvalid && !wvalid && !arvalid && !b_v && !r_v
          && aw_q.size() == 0 && w_q.size() == 0
          && exp_wr.size() == 0 && exp_rd.size() == 0
          && exp_b.size() == 0 && exp_r.size() == 0
          && pend_b == 0 && pend_r == 0
          && wr_out == 0 && rd_out == 0;
    end
    bready = 0;
    rready = 0;
    check("drain_done", done, 1);
    check("rand_err", err, 0);
    check("rand_counts", {wr_out, rd_out}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
